// File: rtl/layer_scheduler.sv
// Multi-layer sequencer: walks a software-loaded descriptor table, launching
// each layer on the datapath and waiting for its done, with a per-layer watchdog.
module layer_scheduler #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned TIMEOUT    = 1_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_layer,
  input  logic [2:0]  cfg_field,
  input  logic [31:0] cfg_wdata,
  input  logic        start,
  input  logic [3:0]  num_layers,
  input  logic        abort,
  input  logic        done,
  output logic        go,
  output logic [2:0]  layer_index,
  output logic [31:0] data_address,
  output logic [31:0] data_size,
  output logic [31:0] weight_address,
  output logic [31:0] weight_size,
  output logic [31:0] result_address,
  output logic        busy,
  output logic        all_done,
  output logic        error
);

  localparam int unsigned TBL_D = 8;
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef struct packed {
    logic [31:0] data_address;
    logic [31:0] data_size;
    logic [31:0] weight_address;
    logic [31:0] weight_size;
    logic [31:0] result_address;
  } desc_t;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH, S_ERR} state_t;

  state_t             state_q;
  desc_t              tbl_q [TBL_D];
  desc_t              desc_q;
  logic [2:0]         idx_q;
  logic [2:0]         last_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               go_q;
  logic               busy_q;
  logic               all_done_q;
  logic               error_q;
  logic [3:0]         n_c;
  logic               timeout_c;

  assign n_c       = (num_layers > 4'(NUM_LAYERS)) ? 4'(NUM_LAYERS) : num_layers;
  assign timeout_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Table entries at or beyond NUM_LAYERS are never written and stay zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < TBL_D; i++) tbl_q[i] <= '0;
      desc_q     <= '0;
      idx_q      <= '0;
      last_q     <= '0;
      cnt_q      <= '0;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      all_done_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      go_q       <= 1'b0;
      all_done_q <= 1'b0;
      if (cfg_we && !busy_q && (32'(cfg_layer) < NUM_LAYERS)) begin
        case (cfg_field)
          3'd0:    tbl_q[cfg_layer].data_address   <= cfg_wdata;
          3'd1:    tbl_q[cfg_layer].data_size      <= cfg_wdata;
          3'd2:    tbl_q[cfg_layer].weight_address <= cfg_wdata;
          3'd3:    tbl_q[cfg_layer].weight_size    <= cfg_wdata;
          3'd4:    tbl_q[cfg_layer].result_address <= cfg_wdata;
          default: ;
        endcase
      end
      case (state_q)
        S_IDLE, S_ERR: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (start) begin
            error_q <= 1'b0;
            idx_q   <= '0;
            desc_q  <= tbl_q[0];
            busy_q  <= 1'b1;
            if (n_c == 4'd0) begin
              state_q    <= S_FINISH;
              all_done_q <= 1'b1;
            end else begin
              last_q  <= 3'(n_c - 4'd1);
              state_q <= S_ISSUE;
              go_q    <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          cnt_q <= '0;
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (done) begin
            if (idx_q == last_q) begin
              state_q    <= S_FINISH;
              all_done_q <= 1'b1;
            end else begin
              idx_q   <= idx_q + 3'd1;
              desc_q  <= tbl_q[idx_q + 3'd1];
              state_q <= S_ISSUE;
              go_q    <= 1'b1;
            end
          end else if (timeout_c) begin
            state_q <= S_ERR;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign go             = go_q;
  assign busy           = busy_q;
  assign all_done       = all_done_q;
  assign error          = error_q;
  assign layer_index    = idx_q;
  assign data_address   = desc_q.data_address;
  assign data_size      = desc_q.data_size;
  assign weight_address = desc_q.weight_address;
  assign weight_size    = desc_q.weight_size;
  assign result_address = desc_q.result_address;

endmodule

// File: tb/tb_layer_scheduler.sv
// Scoreboard bench for layer_scheduler: stimulus queues expected go/all_done
// events with their cycle numbers, a negedge monitor pops and compares them.
module tb_layer_scheduler;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_we;
  logic [2:0]  cfg_layer;
  logic [2:0]  cfg_field;
  logic [31:0] cfg_wdata;
  logic        start;
  logic [3:0]  num_layers;
  logic        abort;
  logic        done;
  logic        go;
  logic [2:0]  layer_index;
  logic [31:0] data_address, data_size, weight_address, weight_size, result_address;
  logic        busy, all_done, error;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    bit          is_done;
    int          cyc;
    logic [2:0]  idx;
    logic [31:0] f [5];
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] exp_tbl [8][5];

  layer_scheduler #(.NUM_LAYERS(4), .TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_layer(cfg_layer),
    .cfg_field(cfg_field), .cfg_wdata(cfg_wdata), .start(start),
    .num_layers(num_layers), .abort(abort), .done(done), .go(go),
    .layer_index(layer_index), .data_address(data_address),
    .data_size(data_size), .weight_address(weight_address),
    .weight_size(weight_size), .result_address(result_address),
    .busy(busy), .all_done(all_done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic exp_t mk(bit d, int c, int i);
    exp_t e;
    e.is_done = d;
    e.cyc     = c;
    e.idx     = 3'(i);
    for (int k = 0; k < 5; k++) e.f[k] = exp_tbl[i][k];
    return e;
  endfunction

  // Monitor: every go or all_done pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (go) begin
      if (exp_q.size() == 0) chk("go_unexpected", 32'(go), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("go_kind", 32'(e.is_done), 32'd0);
        chk("go_cycle", 32'(cyc), 32'(e.cyc));
        chk("go_layer_index", 32'(layer_index), 32'(e.idx));
        chk("go_data_address", data_address, e.f[0]);
        chk("go_data_size", data_size, e.f[1]);
        chk("go_weight_address", weight_address, e.f[2]);
        chk("go_weight_size", weight_size, e.f[3]);
        chk("go_result_address", result_address, e.f[4]);
        chk("go_busy", 32'(busy), 32'd1);
      end
    end
    if (all_done) begin
      if (exp_q.size() == 0) chk("all_done_unexpected", 32'(all_done), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("all_done_kind", 32'(e.is_done), 32'd1);
        chk("all_done_cycle", 32'(cyc), 32'(e.cyc));
        chk("all_done_busy", 32'(busy), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_go"}, 32'(go), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_all_done"}, 32'(all_done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_layer_index"}, 32'(layer_index), 32'd0);
    chk({tag, "_data_address"}, data_address, 32'd0);
    chk({tag, "_data_size"}, data_size, 32'd0);
    chk({tag, "_weight_address"}, weight_address, 32'd0);
    chk({tag, "_weight_size"}, weight_size, 32'd0);
    chk({tag, "_result_address"}, result_address, 32'd0);
  endtask

  task automatic cfg_write(input int layer, input int field, input logic [31:0] val);
    cfg_we = 1'b1; cfg_layer = 3'(layer); cfg_field = 3'(field); cfg_wdata = val;
    tick();
    cfg_we = 1'b0;
    if (layer < 4 && field < 5) exp_tbl[layer][field] = val;
  endtask

  // One run; done returned 'delay' cycles after each go.
  task automatic run(input int nreq, input int delay, input bit abort_l1,
                     input bit issue_done, input bit busy_wr);
    int n = (nreq > 4) ? 4 : nreq;
    exp_q.push_back(mk(n == 0, cyc + 1, 0));
    num_layers = 4'(nreq); start = 1'b1;
    tick();
    start = 1'b0;
    chk("error_cleared_on_start", 32'(error), 32'd0);
    if (n == 0) begin
      chk("busy_finish_n0", 32'(busy), 32'd1);
      tick();
      chk("busy_after_n0", 32'(busy), 32'd0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      chk("busy_issue", 32'(busy), 32'd1);
      done = issue_done && (i == 0);
      tick();
      done = 1'b0;
      for (int t = 1; t < delay; t++) begin
        cfg_we = busy_wr && (i == 0) && (t == 2);
        cfg_layer = 3'd1; cfg_field = 3'd0; cfg_wdata = 32'h0000_0BAD;
        tick();
        cfg_we = 1'b0;
        chk("busy_wait", 32'(busy), 32'd1);
        chk("wait_layer_index", 32'(layer_index), 32'(i));
        chk("wait_data_address", data_address, exp_tbl[i][0]);
      end
      if (abort_l1 && i == 1) begin
        abort = 1'b1; done = 1'b1;
        tick();
        abort = 1'b0; done = 1'b0;
        repeat (20) tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_no_advance", 32'(layer_index), 32'd1);
        return;
      end
      exp_q.push_back(mk(i == n - 1, cyc + 1, (i == n - 1) ? 0 : i + 1));
      done = 1'b1;
      tick();
      done = 1'b0;
    end
    chk("busy_finish", 32'(busy), 32'd1);
    tick();
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  // Launch a 2-layer run, never return done, and check the watchdog timing.
  task automatic to_err();
    int g;
    exp_q.push_back(mk(0, cyc + 1, 0));
    num_layers = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    g = cyc;
    repeat (16) tick();
    chk("wd_error_early", 32'(error), 32'd0);
    chk("wd_busy_early", 32'(busy), 32'd1);
    tick();
    chk("wd_elapsed", 32'(cyc - g), 32'd17);
    chk("wd_error_set", 32'(error), 32'd1);
    chk("wd_busy_err", 32'(busy), 32'd0);
    chk("wd_hold_data_address", data_address, exp_tbl[0][0]);
  endtask

  initial begin
    rstn = 1'b0; cfg_we = 1'b0; cfg_layer = '0; cfg_field = '0; cfg_wdata = '0;
    start = 1'b0; num_layers = '0; abort = 1'b0; done = 1'b0;
    for (int i = 0; i < 8; i++) for (int k = 0; k < 5; k++) exp_tbl[i][k] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 5; k++)
        cfg_write(i, k, 32'h1000_0000 * 32'(k + 1) + 32'h10 * 32'(i) + 32'h7);
    cfg_write(1, 0, 32'h100);
    cfg_write(1, 2, 32'h2000);
    cfg_write(1, 4, 32'h3000);
    cfg_write(6, 0, 32'hDEAD_BEEF);
    cfg_write(0, 5, 32'hDEAD_BEEF);

    run(3, 10, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    run(0, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    run(9, 6, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();

    to_err();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("err_done_ignored", 32'(error), 32'd1);
    run(1, 4, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    to_err();
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    repeat (3) tick();
    chk("err_abort_keeps_error", 32'(error), 32'd1);
    chk("err_abort_busy", 32'(busy), 32'd0);
    run(2, 5, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    run(3, 8, 1'b1, 1'b0, 1'b1);
    run(2, 5, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    exp_q.push_back(mk(0, cyc + 1, 0));
    num_layers = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2 rstn = 1'b0;
    #1 check_zero("async_reset");
    for (int i = 0; i < 8; i++) for (int k = 0; k < 5; k++) exp_tbl[i][k] = '0;
    tick();
    rstn = 1'b1;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    repeat (10) tick();
    check_zero("late_done");

    repeat (5) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/layer_scheduler.md
# layer_scheduler

Multi-layer sequencer for the MNIST inference datapath. Software loads a per-layer descriptor table (data, weight and result buffer addresses and sizes), then issues one start. The block drives the datapath's go/config interface for each layer in turn, waits for each layer's done, and raises a single completion pulse at the end. A watchdog flags a layer whose done never arrives.

## Interface
- NUM_LAYERS, default 4: descriptor table depth, legal range 1..8.
- TIMEOUT, default 1_000_000: maximum cycles to wait for done per layer. A value of 0 disables the watchdog.
- clk  in  1  single clock for the block.
- rstn  in  1  asynchronous, active-low reset.
- cfg_we  in  1  descriptor write strobe.
- cfg_layer  in  3  descriptor entry to write.
- cfg_field  in  3  field select: 0 data_address, 1 data_size, 2 weight_address, 3 weight_size, 4 result_address. Values 5-7 are ignored.
- cfg_wdata  in  32  field value.
- start  in  1  begin a run (pulse).
- num_layers  in  4  number of layers to run, sampled on start.
- abort  in  1  cancel the current run.
- done  in  1  layer-complete pulse from the datapath.
- go  out  1  one-cycle layer launch pulse to the datapath.
- layer_index  out  3  current layer index.
- data_address, data_size, weight_address, weight_size, result_address  out  32 each  descriptor fields of the current layer.
- busy  out  1  high while a run is in progress.
- all_done  out  1  one-cycle pulse when the final layer completes.
- error  out  1  sticky watchdog flag.

## Operation
- States: IDLE, ISSUE, WAIT, FINISH, ERR.
- Descriptor writes:
  - Accepted only when busy=0.
  - A write with cfg_layer ≥ NUM_LAYERS is dropped.
  - A write while busy=1 is dropped.
- IDLE:
  - start=1 captures N = min(num_layers, NUM_LAYERS), clears error and sets layer_index=0.
  - If N=0, go to FINISH. Otherwise go to ISSUE.
- ISSUE:
  - go=1 for exactly this cycle, with the descriptor outputs already showing the entry for layer_index.
  - Clear the wait counter and move to WAIT.
- WAIT:
  - The wait counter increments every cycle. done is sampled only in this state.
  - done=1 and layer_index = N-1: go to FINISH.
  - done=1 and another layer remains: increment layer_index and go to ISSUE.
  - TIMEOUT≠0 and the counter reaches TIMEOUT-1 without done: go to ERR.
- FINISH: all_done=1 for one cycle, then IDLE.
- ERR:
  - error=1, busy=0, all descriptor outputs held.
  - start acts as in IDLE (clears error, begins a new run).
  - abort returns to IDLE with error still set.
- abort:
  - Accepted in ISSUE, WAIT and FINISH; the next state is IDLE.
  - If abort and done arrive in the same cycle, abort wins: no layer advance and no all_done.
  - If abort and start arrive in the same cycle in IDLE or ERR, abort wins and start is ignored.
- start while busy=1 is ignored.
- Descriptor outputs:
  - Registered from the table entry for layer_index.
  - Stable from the go cycle until the cycle after done.
  - Holding these stable is the datapath's only config-stability requirement.
- busy=1 in ISSUE, WAIT and FINISH; 0 otherwise.

## Timing
- Reset (rstn low, asynchronous): state IDLE. go, busy, all_done, error, layer_index and every descriptor output are 0. All table entries are 0. The wait counter is 0.
- start sampled at edge k: go=1 in cycle k+1.
- done sampled in WAIT at edge j: the next layer's go=1 in cycle j+1; for the last layer, all_done=1 in cycle j+1.
- Per-layer overhead: 2 cycles (ISSUE plus the done-to-go turnaround).
- N=0: all_done in cycle k+1, with no go issued.
- done arriving in the ISSUE cycle, or while IDLE/ERR, is ignored.
- The watchdog asserts error on the edge after TIMEOUT WAIT cycles with no done.
- abort takes effect on the next edge. go never asserts after an abort is sampled.

## Test plan
- Program 3 layers (layer 1: data_address=0x100, weight_address=0x2000, result_address=0x3000). start with num_layers=3, and return done 10 cycles after each go. Required:
  - exactly 3 go pulses, with layer_index 0, 1, 2;
  - 0x100/0x2000/0x3000 on the outputs during layer 1;
  - all_done exactly 1 cycle after the third done;
  - busy high for the whole run.
- start with num_layers=0: all_done the next cycle, no go, busy stays 0 apart from the FINISH cycle.
- num_layers=9 with NUM_LAYERS=4: exactly 4 go pulses. A cfg write to layer 6 leaves the table unchanged.
- TIMEOUT=16, done never returned: error=1 16 cycles after WAIT is entered, busy=0. A new start clears error and issues go next cycle.
- Assert abort and done in the same cycle during layer 1 of 3: state returns to IDLE, no further go, no all_done.
- Pulse rstn low mid-WAIT with done arriving after reset: all outputs 0 immediately, and the late done is ignored. cfg writes while busy are dropped, checked by reading the layer outputs on the next run.
